// File: rtl/mips_cpu_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO registers.
// Shift-add multiply, restoring divide on magnitudes, signs re-applied in FIX; MTHI/MTLO write directly.
module mips_cpu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;

  logic               sgn;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    sgn       = (op == 3'd0) || (op == 3'd2);
    a_abs     = (sgn && a[WIDTH-1]) ? -a : a;
    b_abs     = (sgn && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    // Remainder stays below the divisor, so 33 bits cover the trial subtraction.
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -quo : quo;
    rem_fix   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      quo         <= '0;
      rem         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                state  <= MUL;
                cnt    <= '0;
                is_div <= 1'b0;
                acc    <= {{WIDTH{1'b0}}, b_abs};
                mcand  <= a_abs;
                neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= 1'b0;
                dbz    <= 1'b0;
              end
              3'd2, 3'd3: begin
                state  <= DIV;
                cnt    <= '0;
                is_div <= 1'b1;
                quo    <= a_abs;
                rem    <= '0;
                mcand  <= b_abs;
                neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= sgn && a[WIDTH-1];
                dbz    <= (b == '0);
              end
              3'd4:    hi <= a;
              3'd5:    lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          busy <= 1'b1;
          if (cnt == CNT_W'(WIDTH)) begin
            state <= FIX;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV: begin
          busy <= 1'b1;
          if (cnt == CNT_W'(WIDTH)) begin
            state <= FIX;
          end else begin
            if (div_diff[WIDTH]) begin
              rem <= div_shift[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
              rem <= div_diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div) begin
            if (dbz) begin
              div_by_zero <= 1'b1;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Scoreboard bench: stimulus pushes expected HI/LO results and due cycles; a negedge monitor pops and compares.
module tb_mips_cpu_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  mips_cpu_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    int          due;
    logic [1:0]  kind;
    logic [31:0] val;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference results from plain integer arithmetic: {dbz, hi, lo}.
  function automatic logic [64:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    longint unsigned ux, uy, up;
    logic [31:0] q32, r32;
    logic [63:0] pv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    ref_op = '0;
    case (o)
      3'd0: begin p = sx * sy; pv = p; ref_op = {1'b0, pv}; end
      3'd1: begin up = ux * uy; pv = up; ref_op = {1'b0, pv}; end
      3'd2: begin
        if (y == 32'h0) ref_op = {1'b1, 64'h0};
        else begin q = sx / sy; r = sx % sy; ref_op = {1'b0, r[31:0], q[31:0]}; end
      end
      3'd3: begin
        if (y == 32'h0) ref_op = {1'b1, 64'h0};
        else begin q32 = x / y; r32 = x % y; ref_op = {1'b0, r32, q32}; end
      end
      default: ref_op = '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      while (wq.size() > 0 && wq[0].due <= cyc) begin
        wr_t w;
        w = wq.pop_front();
        case (w.kind)
          2'd0: mhi = w.val;
          2'd1: mlo = w.val;
          default: begin mhi = '0; mlo = '0; end
        endcase
      end
      if (div_by_zero && !done) chk("dbz_without_done", 64'(div_by_zero), 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          if (!e.dbz) begin mhi = e.hi; mlo = e.lo; end
        end
      end
      chk("hi", 64'(hi), 64'(mhi));
      chk("lo", 64'(lo), 64'(mlo));
    end
  end

  task automatic run_arith(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [64:0] r;
    int bcnt;
    int k;
    r = ref_op(o, x, y);
    e.due = cyc + 35;
    e.dbz = r[64];
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    k = 0;
    while (!done && k < 60) begin
      if (busy) bcnt++;
      // Operand churn and stray starts while busy must not disturb the op in flight.
      start = busy && ($urandom_range(0, 5) == 0);
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_cycles", 64'(bcnt), 64'd33);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
    wr_t w;
    w.due = cyc + 1;
    w.kind = (o == 3'd4) ? 2'd0 : 2'd1;
    w.val = x;
    wq.push_back(w);
    start = 1'b1; op = o; a = x; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);
  endtask

  task automatic run_nop(input logic [2:0] o);
    start = 1'b1; op = o; a = $urandom; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("nop_busy", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = 32'h1;
      4: pick = 32'($urandom_range(0, 300));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int dc;
    wr_t w;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_arith(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_arith(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mt(3'd4, 32'h1234);
    run_mt(3'd5, 32'h5678);
    run_arith(3'd3, 32'd100, 32'd0);
    run_nop(3'd6);
    run_nop(3'd7);

    // Reset mid-divide: the stray MULTU is ignored and no done ever appears.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    w.due = cyc + 1; w.kind = 2'd2; w.val = '0;
    wq.push_back(w);
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_busy", 64'(busy), 64'd0);
    bc = 0;
    dc = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    chk("abort_busy_cycles", 64'(bc), 64'd0);
    chk("abort_done_pulses", 64'(dc), 64'd0);

    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [31:0] x, y;
      sel = $urandom_range(0, 9);
      x = pick();
      y = pick();
      if (sel <= 5) run_arith(3'($urandom_range(0, 3)), x, y);
      else if (sel <= 7) run_mt(3'($urandom_range(4, 5)), x);
      else run_nop(3'($urandom_range(6, 7)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
Name: mips_cpu_muldiv_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage. The decoder issues a start pulse with latched operands, and the CPU stalls on busy.
- Multiply uses iterative shift-add. Divide uses restoring shift-subtract with sign correction.
- MTHI/MTLO write HI/LO directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 ignored.
- a  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source).
- b  input  32  rt operand (multiplier/divisor).
- busy  output  1  high while an arithmetic op is in flight; CPU stalls on it.
- done  output  1  one-cycle pulse when HI/LO hold the new result.
- div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with b=0.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- Reset has priority over every other input, including mid-operation: the op is aborted, its result is discarded and HI/LO are cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start=1, op 0-3:
  - Latch a and b.
  - For signed ops, latch absolute values and record result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Go to MUL (op 0/1) or DIV (op 2/3). Set counter=0 and busy=1 from the next cycle.
- IDLE, start=1, op 4/5:
  - hi<=a (MTHI) or lo<=a (MTLO) on that edge.
  - busy stays 0; no done pulse.
- IDLE, start=1, op 6/7: no effect.
- MUL: one shift-add step per cycle into a 64-bit accumulator. After 32 steps (counter reaches WIDTH) go to FIX.
- DIV: one restoring step per cycle; remainder 33-bit signed-safe, quotient 32-bit. After 32 steps go to FIX.
- FIX (1 cycle):
  - Apply two's-complement negation per the recorded signs.
  - Write hi/lo. Multiply: hi=upper 32 bits, lo=lower 32 bits. Divide: lo=quotient, hi=remainder.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0; return to IDLE.
- Timing:
  - Start sampled at edge N: busy=1 after edges N+1 through N+33 (33 cycles).
  - hi/lo updated and done=1 after edge N+34.
  - The DONE cycle counts as not busy. A start sampled in the DONE cycle is accepted.
- start while busy=1 is ignored; operands are not re-latched and there is no queueing.
- a/b changes after the start edge have no effect.
- Divide by zero: the op still takes the full 34-cycle latency. hi/lo are NOT written; div_by_zero=1 together with done.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0 (wraps, no trap).
- Signed multiply: full 64-bit two's-complement product. Unsigned ops never negate.
- hi/lo are stable at all times except the FIX edge, MTHI/MTLO edges and reset.

Test Plan:
- Check reset values: assert reset 2 cycles -> hi=lo=0, busy=done=div_by_zero=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles; done after edge N+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi/lo via MTHI/MTLO with 0x1234/0x5678 (busy stays 0), then DIVU a=100, b=0 -> after 34 cycles done=1, div_by_zero=1, hi=0x1234, lo=0x5678.
- DIVU a=100, b=7; at cycle 5 pulse start with op=MULTU, and at cycle 10 assert reset for 1 cycle -> the second start is ignored; after reset busy=0, hi=lo=0, and no done pulse occurs.
